rob_multi_commit: RTL and testbench

Parametrised in-order-retirement reorder buffer for the out-of-order core: accepts one renamed instruction per cycle, marks entries complete from N CDB channels plus the branch unit, and retires up to CommitWidth completed instructions per cycle to the rename/free-list logic. It generalises the single-commit ROB in three ways: arbitrary (non-power-of-two) depth, configurable CDB and commit width, and live branch-misprediction recovery at commit with a redirect PC.

---
 rtl/rob_multi_commit_pkg.sv | 30 +++
 rtl/rob_multi_commit_commit_select.sv | 45 ++++
 rtl/rob_multi_commit.sv | 173 +++++++++++++++++
 tb/tb_rob_multi_commit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_multi_commit_pkg.sv
// Shared types and helpers for the multi-commit reorder buffer.
package rob_multi_commit_pkg;

  localparam int unsigned DefArRegIdWidth  = 5;
  localparam int unsigned DefPhyRegIdWidth = 6;
  localparam int unsigned DefDatapathWidth = 32;

  // One ROB slot; field widths follow the core-wide register/PC widths.
  typedef struct packed {
    logic                              valid;
    logic                              ready;
    logic                              is_branch;
    logic                              mispredicted;
    logic [DefArRegIdWidth-1:0]        ar_id;
    logic [DefPhyRegIdWidth-1:0]       tag;
    logic [DefPhyRegIdWidth-1:0]       old_tag;
    logic [DefDatapathWidth-1:0]       pc;
    logic [DefDatapathWidth-1:0]       target;
  } rob_entry_t;

  // Modulo-depth pointer advance for arbitrary (non power-of-two) depth; inc <= depth.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/rob_multi_commit_commit_select.sv
// Prefix selector: picks the in-order run of ready head slots that may retire.
module rob_commit_select #(
  parameter int unsigned Depth       = 8,
  parameter int unsigned CommitWidth = 2
) (
  input  logic                                   stall,
  input  logic [$clog2(Depth+1)-1:0]             count,
  input  logic [CommitWidth-1:0]                 slot_ready,
  input  logic [CommitWidth-1:0]                 slot_mispred,
  output logic [CommitWidth-1:0]                 commit_valid,
  output logic [$clog2(CommitWidth+1)-1:0]       retire_cnt,
  output logic                                   flush,
  output logic [((CommitWidth > 1) ? $clog2(CommitWidth) : 1)-1:0] flush_slot
);

  localparam int unsigned CntW  = $clog2(Depth+1);
  localparam int unsigned RcW   = $clog2(CommitWidth+1);
  localparam int unsigned SlotW = (CommitWidth > 1) ? $clog2(CommitWidth) : 1;

  logic blocked;

  // Walk slots from the head; the first non-retiring slot or a retiring
  // mispredicted branch stops every younger slot.
  always_comb begin
    commit_valid = '0;
    retire_cnt   = '0;
    flush        = 1'b0;
    flush_slot   = '0;
    blocked      = stall;
    for (int unsigned k = 0; k < CommitWidth; k++) begin
      if (!blocked && (CntW'(k) < count) && slot_ready[k]) begin
        commit_valid[k] = 1'b1;
        retire_cnt      = retire_cnt + RcW'(1);
        if (slot_mispred[k]) begin
          flush      = 1'b1;
          flush_slot = SlotW'(k);
          blocked    = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// In-order-retirement reorder buffer: single insert, NumCdb+BRU completion,
// up to CommitWidth retirements per cycle, misprediction flush at commit.
// Entry field widths come from rob_multi_commit_pkg; the width parameters
// must match the package defaults.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int unsigned ArRegIDWidth  = DefArRegIdWidth,
  parameter int unsigned PhyRegIDWidth = DefPhyRegIdWidth,
  parameter int unsigned DatapathWidth = DefDatapathWidth,
  parameter int unsigned Depth         = 8,
  parameter int unsigned NumCdb        = 2,
  parameter int unsigned CommitWidth   = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  insert_valid_i,
  output logic                                  insert_ready_o,
  input  logic [ArRegIDWidth-1:0]               insert_ar_id_i,
  input  logic [PhyRegIDWidth-1:0]              insert_tag_i,
  input  logic [PhyRegIDWidth-1:0]              insert_old_tag_i,
  input  logic [DatapathWidth-1:0]              insert_pc_i,
  input  logic                                  insert_is_branch_i,
  input  logic [NumCdb-1:0]                     cdb_valid_i,
  input  logic [NumCdb*PhyRegIDWidth-1:0]       cdb_tag_i,
  input  logic                                  bru_valid_i,
  input  logic [PhyRegIDWidth-1:0]              bru_tag_i,
  input  logic                                  bru_mispredicted_i,
  input  logic [DatapathWidth-1:0]              bru_target_i,
  input  logic                                  commit_stall_i,
  output logic [CommitWidth-1:0]                commit_valid_o,
  output logic [CommitWidth*ArRegIDWidth-1:0]   commit_ar_id_o,
  output logic [CommitWidth*PhyRegIDWidth-1:0]  commit_tag_o,
  output logic [CommitWidth*PhyRegIDWidth-1:0]  commit_old_tag_o,
  output logic                                  flush_o,
  output logic [DatapathWidth-1:0]              flush_pc_o,
  output logic [$clog2(Depth+1)-1:0]            count_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth+1);
  localparam int unsigned RcW   = $clog2(CommitWidth+1);
  localparam int unsigned SlotW = (CommitWidth > 1) ? $clog2(CommitWidth) : 1;

  rob_entry_t            entries_q [Depth];
  logic [PtrW-1:0]       head_q;
  logic [PtrW-1:0]       tail_q;
  logic [CntW-1:0]       count_q;

  logic [PtrW-1:0]       slot_idx [CommitWidth];
  logic [CommitWidth-1:0] slot_ready;
  logic [CommitWidth-1:0] slot_mispred;
  logic [CommitWidth-1:0] sel_valid;
  logic [RcW-1:0]        retire_cnt;
  logic                  sel_flush;
  logic [SlotW-1:0]      flush_slot;
  logic                  insert_fire;
  logic                  pc_unused;

  // Gather the registered state of the CommitWidth oldest slots.
  always_comb begin
    for (int unsigned k = 0; k < CommitWidth; k++) begin
      slot_idx[k]     = PtrW'(wrap_add(32'(head_q), k, Depth));
      slot_ready[k]   = entries_q[slot_idx[k]].valid && entries_q[slot_idx[k]].ready;
      slot_mispred[k] = entries_q[slot_idx[k]].is_branch && entries_q[slot_idx[k]].mispredicted;
    end
  end

  rob_commit_select #(
    .Depth       (Depth),
    .CommitWidth (CommitWidth)
  ) u_commit_select (
    .stall        (commit_stall_i),
    .count        (count_q),
    .slot_ready   (slot_ready),
    .slot_mispred (slot_mispred),
    .commit_valid (sel_valid),
    .retire_cnt   (retire_cnt),
    .flush        (sel_flush),
    .flush_slot   (flush_slot)
  );

  assign insert_ready_o = !rst_i && (count_q < CntW'(Depth)) && !flush_o;
  assign insert_fire    = insert_valid_i && insert_ready_o;
  assign flush_o        = !rst_i && sel_flush;
  assign count_o        = rst_i ? '0 : count_q;

  // Retirement outputs: fields of retiring slots, zero elsewhere and during reset.
  always_comb begin
    commit_valid_o   = rst_i ? '0 : sel_valid;
    commit_ar_id_o   = '0;
    commit_tag_o     = '0;
    commit_old_tag_o = '0;
    for (int unsigned k = 0; k < CommitWidth; k++) begin
      if (commit_valid_o[k]) begin
        commit_ar_id_o[k*ArRegIDWidth +: ArRegIDWidth]     = entries_q[slot_idx[k]].ar_id;
        commit_tag_o[k*PhyRegIDWidth +: PhyRegIDWidth]     = entries_q[slot_idx[k]].tag;
        commit_old_tag_o[k*PhyRegIDWidth +: PhyRegIDWidth] = entries_q[slot_idx[k]].old_tag;
      end
    end
    flush_pc_o = flush_o ? entries_q[slot_idx[flush_slot]].target : '0;
  end

  // Stored PCs are for debug visibility only; nothing in the datapath reads them.
  always_comb begin
    pc_unused = 1'b0;
    for (int unsigned e = 0; e < Depth; e++) begin
      pc_unused = pc_unused ^ (^entries_q[e].pc);
    end
  end

  // Entry completion, retirement, insertion and pointer/occupancy update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned e = 0; e < Depth; e++) begin
        entries_q[e] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned e = 0; e < Depth; e++) begin
        if (entries_q[e].valid && !entries_q[e].ready) begin
          if (!entries_q[e].is_branch) begin
            for (int unsigned c = 0; c < NumCdb; c++) begin
              if (cdb_valid_i[c] && (entries_q[e].tag == cdb_tag_i[c*PhyRegIDWidth +: PhyRegIDWidth])) begin
                entries_q[e].ready <= 1'b1;
              end
            end
          end else if (bru_valid_i && (entries_q[e].tag == bru_tag_i)) begin
            entries_q[e].ready        <= 1'b1;
            entries_q[e].mispredicted <= bru_mispredicted_i;
            entries_q[e].target       <= bru_target_i;
          end
        end
      end

      for (int unsigned k = 0; k < CommitWidth; k++) begin
        if (sel_valid[k]) begin
          entries_q[slot_idx[k]].valid <= 1'b0;
          entries_q[slot_idx[k]].ready <= 1'b0;
        end
      end

      if (insert_fire) begin
        entries_q[tail_q] <= '{valid:        1'b1,
                               ready:        1'b0,
                               is_branch:    insert_is_branch_i,
                               mispredicted: 1'b0,
                               ar_id:        insert_ar_id_i,
                               tag:          insert_tag_i,
                               old_tag:      insert_old_tag_i,
                               pc:           insert_pc_i,
                               target:       '0};
      end

      // A flush supersedes every other update made above.
      if (sel_flush) begin
        for (int unsigned e = 0; e < Depth; e++) begin
          entries_q[e].valid <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= PtrW'(wrap_add(32'(head_q), 32'(retire_cnt), Depth));
        tail_q  <= insert_fire ? PtrW'(wrap_add(32'(tail_q), 1, Depth)) : tail_q;
        count_q <= count_q + CntW'(insert_fire) - CntW'(retire_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit (Depth=6, CommitWidth=2, NumCdb=2).
module tb_rob_multi_commit;

  logic        clk;
  logic        rst;
  logic        insert_valid;
  logic        insert_ready;
  logic [4:0]  insert_ar_id;
  logic [5:0]  insert_tag;
  logic [5:0]  insert_old_tag;
  logic [31:0] insert_pc;
  logic        insert_is_branch;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        bru_valid;
  logic [5:0]  bru_tag;
  logic        bru_mispredicted;
  logic [31:0] bru_target;
  logic        commit_stall;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_ar_id;
  logic [11:0] commit_tag;
  logic [11:0] commit_old_tag;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  rob_multi_commit #(
    .ArRegIDWidth  (5),
    .PhyRegIDWidth (6),
    .DatapathWidth (32),
    .Depth         (6),
    .NumCdb        (2),
    .CommitWidth   (2)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .insert_valid_i     (insert_valid),
    .insert_ready_o     (insert_ready),
    .insert_ar_id_i     (insert_ar_id),
    .insert_tag_i       (insert_tag),
    .insert_old_tag_i   (insert_old_tag),
    .insert_pc_i        (insert_pc),
    .insert_is_branch_i (insert_is_branch),
    .cdb_valid_i        (cdb_valid),
    .cdb_tag_i          (cdb_tag),
    .bru_valid_i        (bru_valid),
    .bru_tag_i          (bru_tag),
    .bru_mispredicted_i (bru_mispredicted),
    .bru_target_i       (bru_target),
    .commit_stall_i     (commit_stall),
    .commit_valid_o     (commit_valid),
    .commit_ar_id_o     (commit_ar_id),
    .commit_tag_o       (commit_tag),
    .commit_old_tag_o   (commit_old_tag),
    .flush_o            (flush),
    .flush_pc_o         (flush_pc),
    .count_o            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [5:0]  itag;
    logic        ibr;
    logic [31:0] ipc;
    logic [1:0]  cv;
    logic [5:0]  c0;
    logic [5:0]  c1;
    logic        bv;
    logic [5:0]  bt;
    logic        bm;
    logic [31:0] btgt;
    logic        st;
    logic [1:0]  e_cv;
    logic [5:0]  e_t0;
    logic [5:0]  e_t1;
    logic        e_fl;
    logic [31:0] e_fpc;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ar id is the low 5 bits of the tag and old tag is tag+1, mirroring how inputs are driven.
  task automatic drive(input logic r, input logic iv, input logic [5:0] itag, input logic ibr,
                       input logic [31:0] ipc, input logic [1:0] cv, input logic [5:0] c0,
                       input logic [5:0] c1, input logic bv, input logic [5:0] bt, input logic bm,
                       input logic [31:0] btgt, input logic st);
    rst              = r;
    insert_valid     = iv;
    insert_tag       = itag;
    insert_ar_id     = itag[4:0];
    insert_old_tag   = itag + 6'd1;
    insert_is_branch = ibr;
    insert_pc        = ipc;
    cdb_valid        = cv;
    cdb_tag          = {c1, c0};
    bru_valid        = bv;
    bru_tag          = bt;
    bru_mispredicted = bm;
    bru_target       = btgt;
    commit_stall     = st;
  endtask

  task automatic check_out(input string name, input logic [1:0] ecv, input logic [5:0] et0,
                           input logic [5:0] et1, input logic efl, input logic [31:0] efpc,
                           input logic [2:0] ecnt, input logic erdy);
    logic [11:0] e_tag;
    logic [9:0]  e_ar;
    logic [11:0] e_old;
    e_tag = {ecv[1] ? et1 : 6'd0, ecv[0] ? et0 : 6'd0};
    e_ar  = {ecv[1] ? et1[4:0] : 5'd0, ecv[0] ? et0[4:0] : 5'd0};
    e_old = {ecv[1] ? et1 + 6'd1 : 6'd0, ecv[0] ? et0 + 6'd1 : 6'd0};
    cmp({name, ".commit"}, 64'({commit_valid, commit_tag, commit_ar_id, commit_old_tag}),
        64'({ecv, e_tag, e_ar, e_old}));
    cmp({name, ".flush"}, 64'({flush, flush_pc}), 64'({efl, efpc}));
    cmp({name, ".count"}, 64'(count), 64'(ecnt));
    cmp({name, ".ready"}, 64'(insert_ready), 64'(erdy));
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //                rst iv itag ibr ipc      cv  c0  c1  bv bt bm btgt      st | ecv et0 et1 fl fpc      cnt rdy
    // reset
    vecs.push_back('{1, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 0});
    // fill 10..15, full, dual retire
    vecs.push_back('{0, 1, 10, 0, 32'h40,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 1});
    vecs.push_back('{0, 1, 11, 0, 32'h44,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        1, 1});
    vecs.push_back('{0, 1, 12, 0, 32'h48,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        2, 1});
    vecs.push_back('{0, 1, 13, 0, 32'h4c,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 1, 14, 0, 32'h50,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        4, 1});
    vecs.push_back('{0, 1, 15, 0, 32'h54,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        5, 1});
    vecs.push_back('{0, 1, 16, 0, 32'h58,   3,  10, 11, 0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        6, 0});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   3,  10, 11, 0, 0,       6, 0});
    vecs.push_back('{0, 0, 0,  0, 0,        3,  12, 13, 0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        4, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        3,  14, 15, 0, 0, 0, 0,        0,   3,  12, 13, 0, 0,       4, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   3,  14, 15, 0, 0,       2, 1});
    // out-of-order completion 22, 21, 20
    vecs.push_back('{0, 1, 20, 0, 32'h60,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 1});
    vecs.push_back('{0, 1, 21, 0, 32'h64,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        1, 1});
    vecs.push_back('{0, 1, 22, 0, 32'h68,   0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        2, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        1,  22, 0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        2,  0,  21, 0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        1,  20, 0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   3,  20, 21, 0, 0,       3, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   1,  22, 0,  0, 0,       1, 1});
    // mispredicted branch 30 with younger ready 31,32
    vecs.push_back('{0, 1, 30, 1, 32'h100,  0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 1});
    vecs.push_back('{0, 1, 31, 0, 32'h104,  0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        1, 1});
    vecs.push_back('{0, 1, 32, 0, 32'h108,  0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        2, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        3,  31, 32, 0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  1, 30, 1, 32'h200, 0,   0,  0,  0, 0, 0,        3, 1});
    vecs.push_back('{0, 1, 33, 0, 32'h10c,  0,  0,  0,  0, 0, 0, 0,        0,   1,  30, 0, 1, 32'h200,  3, 0});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 1});
    vecs.push_back('{0, 0, 0,  0, 0,        0,  0,  0,  0, 0, 0, 0,        0,   0,  0,  0, 0, 0,        0, 1});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].iv, vecs[i].itag, vecs[i].ibr, vecs[i].ipc, vecs[i].cv,
            vecs[i].c0, vecs[i].c1, vecs[i].bv, vecs[i].bt, vecs[i].bm, vecs[i].btgt, vecs[i].st);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].e_cv, vecs[i].e_t0, vecs[i].e_t1, vecs[i].e_fl,
                vecs[i].e_fpc, vecs[i].e_cnt, vecs[i].e_rdy);
    end

    // Wrap: stream 40..48 through 6 entries starting at pointer 0; each tag completes
    // the cycle after insert and retires the cycle after that.
    for (int i = 0; i < 12; i++) begin
      int ins_before;
      int ret_before;
      ins_before = (i < 9) ? i : 9;
      ret_before = (i < 2) ? 0 : ((i - 2 > 9) ? 9 : i - 2);
      @(negedge clk);
      drive(0, (i < 9), 6'(40 + i), 0, 32'(32'h400 + 4 * i),
            {1'b0, (i >= 1 && i <= 9)}, 6'(40 + i - 1), 0, 0, 0, 0, 0, 0);
      #1;
      check_out($sformatf("wrap%0d", i), {1'b0, (i >= 2 && i <= 10)}, 6'(40 + i - 2), 0, 0, 0,
                3'(ins_before - ret_before), 1);
    end

    // Stall: correctly predicted branch 50 plus 51, both ready, held 3 cycles.
    @(negedge clk); drive(0, 1, 50, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("stall0", 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 1, 51, 0, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("stall1", 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 51, 0, 1, 50, 0, 32'h300, 0);
    #1; check_out("stall2", 0, 0, 0, 0, 0, 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1; check_out($sformatf("stall_hold%0d", i), 0, 0, 0, 0, 0, 2, 1);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("stall_release", 3, 50, 51, 0, 0, 2, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("stall_drained", 0, 0, 0, 0, 0, 0, 1);

    // Reset with 4 live entries, then normal operation afterwards.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(0, 1, 6'(60 + i), 0, 32'(32'h600 + 4 * i), 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check_out($sformatf("rst_fill%0d", i), 0, 0, 0, 0, 0, 3'(i), 1);
    end
    @(negedge clk); drive(1, 1, 64, 0, 32'h610, 3, 60, 61, 0, 0, 0, 0, 0);
    #1; check_out("rst_assert", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("rst_release", 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 1, 70, 0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("post_rst0", 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 70, 0, 0, 0, 0, 0, 0);
    #1; check_out("post_rst1", 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_out("post_rst2", 1, 70, 0, 0, 0, 1, 1);
    @(negedge clk);
    #1; check_out("post_rst3", 0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
